// File: rtl/sw_array_sched_if.sv
// Bus bundle between the array sequencer and its surroundings: Y shift-FIFO,
// score FIFO, session control and the PE array enable/score lanes.
// Signal suffixes are from the sequencer's point of view.
interface sw_array_sched_if #(
  parameter int SEQ_DEPTH = 50,
  parameter int SCORE_W   = 16
);
  logic                         open_i;
  logic                         wr_open_i;
  logic                         y_sr_en_o;
  logic [1:0]                   y_dout_i;
  logic                         y_dout_valid_i;
  logic                         y_sr_empty_i;
  logic                         y_ff_empty_i;
  logic [1:0]                   y_o;
  logic                         y_valid_o;
  logic [SEQ_DEPTH-1:0]         proc_en_o;
  logic [SEQ_DEPTH*SCORE_W-1:0] score_pipe_i;
  logic [31:0]                  sc_data_o;
  logic                         sc_wren_o;
  logic                         sc_full_i;
  logic                         sc_empty_i;
  logic                         eof_o;
  logic                         busy_o;

  // Sequencer side
  modport slave (
    input  open_i, wr_open_i, y_dout_i, y_dout_valid_i, y_sr_empty_i,
           y_ff_empty_i, score_pipe_i, sc_full_i, sc_empty_i,
    output y_sr_en_o, y_o, y_valid_o, proc_en_o, sc_data_o, sc_wren_o,
           eof_o, busy_o
  );

  // Environment side (FIFOs, PE array, host session)
  modport master (
    output open_i, wr_open_i, y_dout_i, y_dout_valid_i, y_sr_empty_i,
           y_ff_empty_i, score_pipe_i, sc_full_i, sc_empty_i,
    input  y_sr_en_o, y_o, y_valid_o, proc_en_o, sc_data_o, sc_wren_o,
           eof_o, busy_o
  );
endinterface

// File: rtl/sw_array_sched.sv
// Smith-Waterman systolic array sequencer: fetches Y characters, broadcasts
// them into the PE chain, grows/retires the PE enable mask, drains every PE
// score into the score FIFO after each step and signals EOF once flushed.
module sw_array_sched #(
  parameter int SEQ_DEPTH = 50,
  parameter int SCORE_W   = 16,
  parameter int CNT_W     = 16
) (
  input  logic            bus_clk,
  input  logic            rst_n,
  sw_array_sched_if.slave bus
);

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_LOAD, S_PROC, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SEQ_DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(SEQ_DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]     drain_idx_q, drain_idx_d;
  logic                 final_q, final_d;
  logic                 y_sr_en_q, y_sr_en_d;
  logic [1:0]           y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic [SEQ_DEPTH-1:0] proc_en_q, proc_en_d;
  logic [31:0]          sc_data_q, sc_data_d;
  logic                 sc_wren_q, sc_wren_d;
  logic                 eof_q, eof_d;

  logic [SEQ_DEPTH-1:0] load_mask, flush_mask;
  logic [SCORE_W-1:0]   pe_score;
  logic [31:0]          sc_word;

  // Decode counters into one-hot PE masks and select the PE score being drained;
  // an out-of-range counter yields an empty mask, so saturated counts touch nothing
  always_comb begin
    load_mask  = '0;
    flush_mask = '0;
    pe_score   = '0;
    for (int i = 0; i < SEQ_DEPTH; i++) begin
      if (load_cnt_q == CNT_W'(i))  load_mask[i]  = 1'b1;
      if (flush_cnt_q == CNT_W'(i)) flush_mask[i] = 1'b1;
      if (drain_idx_q == CNT_W'(i)) pe_score = bus.score_pipe_i[i*SCORE_W +: SCORE_W];
    end
    sc_word = '0;
    sc_word[SCORE_W-1:0] = pe_score;
  end

  // Next-state and registered-output logic; a closed session clears everything
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drain_idx_d = drain_idx_q;
    final_d     = final_q;
    y_sr_en_d   = y_sr_en_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    proc_en_d   = proc_en_q;
    sc_data_d   = sc_data_q;
    sc_wren_d   = sc_wren_q;
    eof_d       = eof_q;
    if (!bus.open_i) begin
      state_d     = S_FETCH;
      load_cnt_d  = '0;
      flush_cnt_d = '0;
      drain_idx_d = '0;
      final_d     = 1'b0;
      y_sr_en_d   = 1'b0;
      y_d         = '0;
      y_valid_d   = 1'b0;
      proc_en_d   = '0;
      sc_data_d   = '0;
      sc_wren_d   = 1'b0;
      eof_d       = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          y_sr_en_d = 1'b1;
          sc_wren_d = 1'b0;
          if (bus.sc_empty_i && final_q && (flush_cnt_q == DEPTH_C)) eof_d = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          y_sr_en_d = 1'b0;
          state_d   = S_LOAD;
        end
        S_LOAD: begin
          // The writer is done only when it has closed and both FIFO stages are dry
          if (!final_q) final_d = !bus.wr_open_i && bus.y_sr_empty_i && bus.y_ff_empty_i;
          if (bus.y_dout_valid_i && !final_q) begin
            y_d       = bus.y_dout_i;
            y_valid_d = 1'b1;
            if (load_cnt_q < DEPTH_C) begin
              proc_en_d  = proc_en_q | load_mask;
              load_cnt_d = load_cnt_q + ONE_C;
            end
            state_d = S_PROC;
          end else if (final_q && (flush_cnt_q < DEPTH_C)) begin
            // Retire the oldest PE; a coincident enable of the same PE takes priority
            y_valid_d   = 1'b1;
            proc_en_d   = (proc_en_q & ~flush_mask) | load_mask;
            flush_cnt_d = flush_cnt_q + ONE_C;
            if (load_cnt_q < DEPTH_C) load_cnt_d = load_cnt_q + ONE_C;
            state_d = S_PROC;
          end else begin
            y_valid_d = 1'b0;
            state_d   = S_FETCH;
          end
        end
        S_PROC: begin
          y_valid_d   = 1'b0;
          drain_idx_d = '0;
          state_d     = S_DRAIN;
        end
        S_DRAIN: begin
          if (!bus.sc_full_i) begin
            sc_wren_d = 1'b1;
            sc_data_d = sc_word;
            if (drain_idx_q == LAST_C) state_d = S_FETCH;
            else                       drain_idx_d = drain_idx_q + ONE_C;
          end else begin
            sc_wren_d = 1'b0;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      load_cnt_q  <= '0;
      flush_cnt_q <= '0;
      drain_idx_q <= '0;
      final_q     <= 1'b0;
      y_sr_en_q   <= 1'b0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      proc_en_q   <= '0;
      sc_data_q   <= '0;
      sc_wren_q   <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      drain_idx_q <= drain_idx_d;
      final_q     <= final_d;
      y_sr_en_q   <= y_sr_en_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      proc_en_q   <= proc_en_d;
      sc_data_q   <= sc_data_d;
      sc_wren_q   <= sc_wren_d;
      eof_q       <= eof_d;
    end
  end

  assign bus.y_sr_en_o = y_sr_en_q;
  assign bus.y_o       = y_q;
  assign bus.y_valid_o = y_valid_q;
  assign bus.proc_en_o = proc_en_q;
  assign bus.sc_data_o = sc_data_q;
  assign bus.sc_wren_o = sc_wren_q;
  assign bus.eof_o     = eof_q;
  assign bus.busy_o    = (state_q != S_FETCH);

endmodule

// File: tb/tb_sw_array_sched.sv
// Directed bench for sw_array_sched with a 4-PE array.
module tb_sw_array_sched;
  localparam int DEPTH = 4;
  localparam int SW    = 16;

  logic bus_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 bus_clk = ~bus_clk;

  sw_array_sched_if #(.SEQ_DEPTH(DEPTH), .SCORE_W(SW)) ifc ();

  sw_array_sched #(.SEQ_DEPTH(DEPTH), .SCORE_W(SW), .CNT_W(16)) dut (
    .bus_clk (bus_clk),
    .rst_n   (rst_n),
    .bus     (ifc)
  );

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int tot_words = 0;
  int tot_valid = 0;
  logic [31:0] words[$];
  logic [DEPTH-1:0] pe_hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the rising edge and log activity
  task automatic step();
    @(posedge bus_clk);
    #1;
    if (ifc.sc_wren_o === 1'b1) begin
      words.push_back(ifc.sc_data_o);
      tot_words++;
    end
    if (ifc.y_valid_o === 1'b1) begin
      vcount++;
      tot_valid++;
      pe_hist.push_back(ifc.proc_en_o);
    end
  endtask

  task automatic wait_sr_en(input string tag, input int budget);
    int n = 0;
    while (ifc.y_sr_en_o !== 1'b1 && n < budget) begin step(); n++; end
    chk(tag, ifc.y_sr_en_o, 1);
  endtask

  task automatic wait_eof(input string tag, input int budget);
    int n = 0;
    while (ifc.eof_o !== 1'b1 && n < budget) begin step(); n++; end
    chk(tag, ifc.eof_o, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sr_en"}, ifc.y_sr_en_o, 0);
    chk({tag, "_y"},     ifc.y_o, 0);
    chk({tag, "_yv"},    ifc.y_valid_o, 0);
    chk({tag, "_pe"},    ifc.proc_en_o, 0);
    chk({tag, "_data"},  ifc.sc_data_o, 0);
    chk({tag, "_wren"},  ifc.sc_wren_o, 0);
    chk({tag, "_eof"},   ifc.eof_o, 0);
    chk({tag, "_busy"},  ifc.busy_o, 0);
  endtask

  initial begin
    logic [5:0] wren_hist;
    logic [31:0] orv;

    ifc.open_i         = 1'b1;
    ifc.wr_open_i      = 1'b1;
    ifc.y_dout_i       = 2'd0;
    ifc.y_dout_valid_i = 1'b0;
    ifc.y_sr_empty_i   = 1'b1;
    ifc.y_ff_empty_i   = 1'b1;
    ifc.score_pipe_i   = {16'd4, 16'd3, 16'd2, 16'd1};
    ifc.sc_full_i      = 1'b0;
    ifc.sc_empty_i     = 1'b0;

    // ---- Reset held: inputs wiggle, outputs stay 0
    for (int i = 0; i < 3; i++) begin
      ifc.y_dout_valid_i = ~ifc.y_dout_valid_i;
      ifc.y_dout_i       = 2'(i + 1);
      ifc.sc_empty_i     = ~ifc.sc_empty_i;
      #7;
    end
    chk_all_zero("rst");
    ifc.y_dout_valid_i = 1'b0;
    ifc.sc_empty_i     = 1'b0;
    @(negedge bus_clk);
    rst_n = 1'b1;

    // ---- Empty polling: FETCH/WAIT/LOAD every 3 cycles
    wait_sr_en("poll_first", 5);
    step(); chk("poll_c1", ifc.y_sr_en_o, 0);
    step(); chk("poll_c2", ifc.y_sr_en_o, 0);
    step(); chk("poll_c3", ifc.y_sr_en_o, 1);
    chk("poll_pe", ifc.proc_en_o, 4'b0000);

    // ---- Single character
    words.delete(); vcount = 0; tot_words = 0; tot_valid = 0; pe_hist.delete();
    ifc.y_dout_i = 2'd3; ifc.y_dout_valid_i = 1'b1;
    step(); step();
    ifc.y_dout_valid_i = 1'b0;
    chk("c1_yv", ifc.y_valid_o, 1);
    chk("c1_y", ifc.y_o, 3);
    chk("c1_pe", ifc.proc_en_o, 4'b0001);
    chk("c1_busy", ifc.busy_o, 1);
    wren_hist = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      wren_hist[k] = ifc.sc_wren_o;
    end
    chk("c1_wren_pattern", wren_hist, 6'b011110);
    chk("c1_next_fetch", ifc.y_sr_en_o, 1);
    chk("c1_nwords", words.size(), 4);
    for (int k = 0; k < words.size(); k++) chk("c1_word", words[k], k + 1);
    chk("c1_vcount", vcount, 1);

    // ---- Second character with a 5-cycle score FIFO stall after word 2
    words.delete();
    ifc.y_dout_i = 2'd1; ifc.y_dout_valid_i = 1'b1;
    step(); step();
    ifc.y_dout_valid_i = 1'b0;
    chk("c2_y", ifc.y_o, 1);
    chk("c2_pe", ifc.proc_en_o, 4'b0011);
    step(); step(); step();
    ifc.sc_full_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_stall_wren", ifc.sc_wren_o, 0);
    end
    ifc.sc_full_i = 1'b0;
    step(); step(); step();
    chk("bp_nwords", words.size(), 4);
    for (int k = 0; k < words.size(); k++) chk("bp_word", words[k], k + 1);
    chk("bp_fetch", ifc.y_sr_en_o, 1);

    // ---- Writer closes: flush the array, EOF gated by score FIFO empty
    words.delete(); vcount = 0;
    ifc.wr_open_i = 1'b0;
    for (int k = 0; k < 50; k++) step();
    chk("fl_vcount", vcount, 4);
    chk("fl_nwords", words.size(), 16);
    for (int k = 0; k < words.size(); k++) chk("fl_word", words[k], (k % 4) + 1);
    chk("fl_eof_gated", ifc.eof_o, 0);
    chk("fl_pe_final", ifc.proc_en_o, 4'b0000);
    chk("pe_hist_n", pe_hist.size(), 6);
    if (pe_hist.size() == 6) begin
      chk("pe_seq0", pe_hist[0], 4'b0001);
      chk("pe_seq1", pe_hist[1], 4'b0011);
      chk("pe_seq2", pe_hist[2], 4'b0110);
      chk("pe_seq3", pe_hist[3], 4'b1100);
      chk("pe_seq4", pe_hist[4], 4'b1000);
      chk("pe_seq5", pe_hist[5], 4'b0000);
    end
    chk("tot_valid", tot_valid, 6);
    chk("tot_words", tot_words, 24);
    ifc.sc_empty_i = 1'b1;
    wait_eof("fl_eof", 6);
    ifc.sc_empty_i = 1'b0;
    step(); step(); step(); step();
    chk("fl_eof_sticky", ifc.eof_o, 1);

    // ---- Session close, then a zero-length stream
    ifc.open_i = 1'b0;
    step();
    chk("close_pe", ifc.proc_en_o, 0);
    chk("close_eof", ifc.eof_o, 0);
    chk("close_busy", ifc.busy_o, 0);
    ifc.open_i = 1'b1;
    ifc.score_pipe_i = '0;
    words.delete(); vcount = 0;
    for (int k = 0; k < 50; k++) step();
    chk("zl_vcount", vcount, 4);
    chk("zl_nwords", words.size(), 16);
    orv = '0;
    foreach (words[k]) orv = orv | words[k];
    chk("zl_words_zero", orv, 0);
    chk("zl_eof_gated", ifc.eof_o, 0);
    ifc.sc_empty_i = 1'b1;
    wait_eof("zl_eof", 6);
    ifc.sc_empty_i = 1'b0;

    // ---- Abort mid-drain at drain_idx 2, then restart
    ifc.open_i = 1'b0;
    step();
    ifc.open_i       = 1'b1;
    ifc.wr_open_i    = 1'b1;
    ifc.score_pipe_i = {16'd4, 16'd3, 16'd2, 16'd1};
    wait_sr_en("ab_fetch", 5);
    ifc.y_dout_i = 2'd2; ifc.y_dout_valid_i = 1'b1;
    step(); step();
    ifc.y_dout_valid_i = 1'b0;
    chk("ab_pe_load", ifc.proc_en_o, 4'b0001);
    words.delete();
    step(); step(); step();
    chk("ab_partial", words.size(), 2);
    ifc.open_i = 1'b0;
    step();
    chk("ab_wren", ifc.sc_wren_o, 0);
    chk("ab_pe", ifc.proc_en_o, 0);
    chk("ab_eof", ifc.eof_o, 0);
    ifc.open_i = 1'b1;
    words.delete();
    step();
    chk("rs_fetch", ifc.y_sr_en_o, 1);
    ifc.y_dout_i = 2'd0; ifc.y_dout_valid_i = 1'b1;
    step(); step();
    ifc.y_dout_valid_i = 1'b0;
    chk("rs_pe", ifc.proc_en_o, 4'b0001);
    chk("rs_yv", ifc.y_valid_o, 1);
    for (int k = 0; k < 6; k++) step();
    chk("rs_nwords", words.size(), 4);
    if (words.size() == 4) begin
      chk("rs_w0", words[0], 1);
      chk("rs_w3", words[3], 4);
    end

    // ---- Asynchronous reset in the middle of a drain
    ifc.y_dout_i = 2'd3; ifc.y_dout_valid_i = 1'b1;
    step(); step();
    ifc.y_dout_valid_i = 1'b0;
    step(); step();
    chk("ar_pre_wren", ifc.sc_wren_o, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_array_sched.md
# sw_array_sched

Sequencing controller for the Smith-Waterman systolic PE array. It pulls 2-bit Y characters from the Y shift-FIFO and broadcasts each one into the array. It grows and then retires the per-PE enable mask, and drains all SEQ_DEPTH PE scores into the 32-bit score FIFO after every character. It sits between the Xillybus-facing Y/score FIFOs and the `sw_pe` chain, and it raises the read-stream EOF once the array has been fully flushed.

## Interface
- SEQ_DEPTH, 50, number of PEs in the array (≥2)
- SCORE_W, 16, PE score width (≤32)
- CNT_W, 16, width of the internal counters (must hold SEQ_DEPTH+3)
- bus_clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- open_i  in  1  read session open; low = synchronous clear to reset values
- wr_open_i  in  1  Y writer still open
- y_sr_en_o  out  1  shift-FIFO read strobe
- y_dout_i  in  2  Y character from shift-FIFO
- y_dout_valid_i  in  1  y_dout_i valid
- y_sr_empty_i, y_ff_empty_i  in  1 each  shift register / backing FIFO empty
- y_o  out  2  character broadcast to PE 0
- y_valid_o  out  1  character strobe to the array
- proc_en_o  out  SEQ_DEPTH  per-PE enable; PE i reset = !proc_en_o[i]
- score_pipe_i  in  SEQ_DEPTH*SCORE_W  flat PE scores, PE i at [i*SCORE_W +: SCORE_W]
- sc_data_o  out  32  score word, zero-extended
- sc_wren_o  out  1  score FIFO write enable
- sc_full_i, sc_empty_i  in  1 each  score FIFO full / empty
- eof_o  out  1  stream complete (sticky)
- busy_o  out  1  high whenever the state is not FETCH

## Operation
- Reset (rst_n low, or open_i low on a clock edge) drives all outputs to 0, sets state=FETCH, and clears load_cnt, flush_cnt, drain_idx and final_flag.
- FETCH:
  - Drive y_sr_en_o=1 and sc_wren_o=0.
  - If sc_empty_i && final_flag && flush_cnt==SEQ_DEPTH, set eof_o=1. eof_o holds until reset.
  - Next state: WAIT.
- WAIT: y_sr_en_o=0. Next state: LOAD.
- LOAD:
  - If !final_flag, final_flag ← !wr_open_i && y_sr_empty_i && y_ff_empty_i. The branch selection below uses the old final_flag.
  - Load branch (y_dout_valid_i && !final_flag):
    - y_o←y_dout_i, y_valid_o←1.
    - Set proc_en_o[load_cnt] only if load_cnt<SEQ_DEPTH.
    - load_cnt saturates at SEQ_DEPTH.
    - Next state: PROC.
  - Flush branch (final_flag && flush_cnt<SEQ_DEPTH):
    - y_valid_o←1, y_o unchanged.
    - Clear proc_en_o[flush_cnt].
    - Set proc_en_o[load_cnt] if load_cnt<SEQ_DEPTH; on an index collision, set wins.
    - flush_cnt++, load_cnt++ (saturating).
    - Next state: PROC.
  - Otherwise: y_valid_o←0. Next state: FETCH (poll).
- PROC: y_valid_o←0, drain_idx←0. Next state: DRAIN.
- DRAIN:
  - If !sc_full_i: sc_wren_o←1 and sc_data_o←{0, score_pipe_i[drain_idx]}. If drain_idx==SEQ_DEPTH-1, go to FETCH; else drain_idx++.
  - If sc_full_i: sc_wren_o←0 and hold drain_idx. No word is lost or duplicated.
- sc_wren_o stays high across consecutive DRAIN writes and drops in the FETCH that follows.

## Timing
- Without backpressure, one character takes SEQ_DEPTH+4 cycles: FETCH, WAIT, LOAD, PROC, then SEQ_DEPTH×DRAIN.
- y_sr_en_o is a single-cycle pulse. y_dout_i is sampled 2 cycles after the pulse is registered.
- y_valid_o is high for exactly 1 cycle per processed character and per flush step.
- The first score word appears at sc_wren_o 2 cycles after y_valid_o rises. Words are in PE order 0..SEQ_DEPTH-1.
- Exactly SEQ_DEPTH score words are written per y_valid_o pulse. Total = SEQ_DEPTH × (chars + SEQ_DEPTH).
- An empty-poll loop (no valid char, not final) repeats every 3 cycles: FETCH, WAIT, LOAD.
- eof_o rises at a FETCH edge at least SEQ_DEPTH+4 cycles after the last flush step, and only once the score FIFO reports empty.
- An open_i drop mid-DRAIN aborts immediately: sc_wren_o=0 on the next edge, and the partial score burst is not resumed.
- An async reset mid-operation clears all state and outputs without waiting for a clock edge.

## Test plan
- Reset check (SEQ_DEPTH=4): hold rst_n low and toggle inputs → all outputs read 0. Release rst_n with open_i=1 and no data → y_sr_en_o pulses every 3 cycles, proc_en_o=4'b0000.
- Single character: SEQ_DEPTH=4, y_dout_i=2'd3 valid, score_pipe_i={16'd4,16'd3,16'd2,16'd1} (PE3..PE0).
  - proc_en_o=4'b0001 and y_o=3.
  - Score words 1,2,3,4 are written on 4 consecutive cycles; character period = 8 cycles.
- Backpressure: assert sc_full_i for 5 cycles after the 2nd drain word → sc_wren_o=0 during the stall. Exactly 4 words total, 3rd word = PE2 score, no duplicates.
- Flush/EOF: load 2 chars, then drop wr_open_i with both FIFO empties high.
  - proc_en_o sequence 0001 → 0011 → 0110 → 1100 → 1000 → 0000.
  - 6 y_valid_o pulses and 24 score words.
  - eof_o=1 only after sc_empty_i=1.
- Zero-length stream (writer closed, FIFOs empty): 4 flush steps → 16 words all zero-scored PEs, then eof_o.
- Abort: drop open_i at drain_idx=2 → next edge sc_wren_o=0, proc_en_o=0, eof_o=0. Reopening restarts from FETCH with load_cnt=0.
